// File: rtl/angle_ctrl_pkg.sv
// Package shared by the angle start-up sequencer and its sub-blocks.
// It holds the FSM state width and the state codes. The state register is a
// plain vector, so an illegal code 5..7 can still be observed and recovered from.
package angle_ctrl_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] S_ALIGN  = 3'd1;
    localparam logic [STATE_W-1:0] S_RAMP   = 3'd2;
    localparam logic [STATE_W-1:0] S_RUN    = 3'd3;
    localparam logic [STATE_W-1:0] S_RAMPDN = 3'd4;

endpackage

// File: rtl/ramp_tick_gen.sv
// ramp_tick_gen: free-running step divider for the prescaler ramps.
//   aclk   in   system clock (rising edge)
//   reset  in   synchronous, active-high reset
//   clr    in   forces the counter to 0 and suppresses tick in this cycle
//   div    in   tick period minus one
//   tick   out  one-cycle pulse every div+1 cycles
module ramp_tick_gen
    import angle_ctrl_pkg::*;
#(
    parameter int RAMP_DIV_WIDTH = 16
) (
    input  logic                      aclk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic [RAMP_DIV_WIDTH-1:0] div,
    output logic                      tick
);

    localparam logic [RAMP_DIV_WIDTH-1:0] CNT_ONE = RAMP_DIV_WIDTH'(1);

    logic [RAMP_DIV_WIDTH-1:0] cnt_q;

    // The compare uses >= so that a counter somehow above div still wraps at once.
    assign tick = (!clr) && (cnt_q >= div);

    // Divider counter: the counter clears on clr and wraps after it reaches div.
    always_ff @(posedge aclk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (cnt_q >= div) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

endmodule

// File: rtl/angle_ramp_ctrl.sv
// angle_ramp_ctrl: open-loop start-up sequencer for angle_gen.
// The sequence is IDLE -> ALIGN (rotor held at angle 0) -> RAMP (prescaler
// falls to target) -> RUN. It then goes RAMPDN (prescaler climbs back to
// start) -> IDLE.
//   aclk, reset                 clock and synchronous active-high reset
//   start, stop                 level requests (start only honoured in IDLE)
//   prescaler_start/_target     ramp end points, latched on start
//   ramp_div, align_time        ramp step period-1 and align length-1, latched on start
//   angle_prescaler             registered prescaler for angle_gen
//   angle_gen_resetn, pwm_en    registered angle_gen reset and PWM enable
//   state, running, done        status: FSM code, RUN flag, end-of-rampdown pulse
module angle_ramp_ctrl
    import angle_ctrl_pkg::*;
#(
    parameter int PRESCALER_WIDTH = 12,
    parameter int RAMP_DIV_WIDTH  = 16,
    parameter int ALIGN_WIDTH     = 24
) (
    input  logic                       aclk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stop,
    input  logic [PRESCALER_WIDTH-1:0] prescaler_start,
    input  logic [PRESCALER_WIDTH-1:0] prescaler_target,
    input  logic [RAMP_DIV_WIDTH-1:0]  ramp_div,
    input  logic [ALIGN_WIDTH-1:0]     align_time,
    output logic [PRESCALER_WIDTH-1:0] angle_prescaler,
    output logic                       angle_gen_resetn,
    output logic                       pwm_en,
    output logic [STATE_W-1:0]         state,
    output logic                       running,
    output logic                       done
);

    localparam logic [PRESCALER_WIDTH-1:0] PRESC_ONE = PRESCALER_WIDTH'(1);
    localparam logic [ALIGN_WIDTH-1:0]     ALIGN_ONE = ALIGN_WIDTH'(1);

    logic [STATE_W-1:0]         state_q;
    logic [PRESCALER_WIDTH-1:0] presc_q;
    logic                       resetn_q;
    logic                       pwm_q;
    logic                       running_q;
    logic                       done_q;
    logic                       clr_q;
    logic [PRESCALER_WIDTH-1:0] start_q;
    logic [PRESCALER_WIDTH-1:0] target_q;
    logic [RAMP_DIV_WIDTH-1:0]  div_q;
    logic [ALIGN_WIDTH-1:0]     align_q;
    logic [ALIGN_WIDTH-1:0]     align_cnt_q;
    logic                       tick_d;

    // clr_q is high in the first cycle of every state, so each state's first
    // step lands div+1 cycles after entry.
    ramp_tick_gen #(
        .RAMP_DIV_WIDTH (RAMP_DIV_WIDTH)
    ) u_tick (
        .aclk  (aclk),
        .reset (reset),
        .clr   (clr_q),
        .div   (div_q),
        .tick  (tick_d)
    );

    assign angle_prescaler  = presc_q;
    assign angle_gen_resetn = resetn_q;
    assign pwm_en           = pwm_q;
    assign state            = state_q;
    assign running          = running_q;
    assign done             = done_q;

    // Sequencer FSM: state, registered outputs, config latches and align counter.
    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            resetn_q    <= 1'b0;
            pwm_q       <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            clr_q       <= 1'b1;
            start_q     <= '0;
            target_q    <= '0;
            div_q       <= '0;
            align_q     <= '0;
            align_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            clr_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    resetn_q  <= 1'b0;
                    running_q <= 1'b0;
                    // A simultaneous stop vetoes the start.
                    if (start && !stop) begin
                        start_q     <= prescaler_start;
                        target_q    <= prescaler_target;
                        div_q       <= ramp_div;
                        align_q     <= align_time;
                        presc_q     <= prescaler_start;
                        align_cnt_q <= '0;
                        pwm_q       <= 1'b1;
                        clr_q       <= 1'b1;
                        state_q     <= S_ALIGN;
                    end else begin
                        pwm_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_ALIGN: begin
                    if (stop) begin
                        pwm_q    <= 1'b0;
                        resetn_q <= 1'b0;
                        clr_q    <= 1'b1;
                        state_q  <= S_IDLE;
                    end else if (align_cnt_q >= align_q) begin
                        resetn_q <= 1'b1;
                        clr_q    <= 1'b1;
                        state_q  <= S_RAMP;
                    end else begin
                        align_cnt_q <= align_cnt_q + ALIGN_ONE;
                    end
                end
                S_RAMP: begin
                    // Using <= here also covers a target at or above the start value.
                    if (stop) begin
                        clr_q   <= 1'b1;
                        state_q <= S_RAMPDN;
                    end else if (presc_q <= target_q) begin
                        running_q <= 1'b1;
                        clr_q     <= 1'b1;
                        state_q   <= S_RUN;
                    end else if (tick_d) begin
                        presc_q <= presc_q - PRESC_ONE;
                    end else begin
                        presc_q <= presc_q;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        running_q <= 1'b0;
                        clr_q     <= 1'b1;
                        state_q   <= S_RAMPDN;
                    end else begin
                        running_q <= 1'b1;
                    end
                end
                S_RAMPDN: begin
                    // stop is deliberately not looked at here.
                    if (presc_q >= start_q) begin
                        pwm_q    <= 1'b0;
                        resetn_q <= 1'b0;
                        done_q   <= 1'b1;
                        clr_q    <= 1'b1;
                        state_q  <= S_IDLE;
                    end else if (tick_d) begin
                        presc_q <= presc_q + PRESC_ONE;
                    end else begin
                        presc_q <= presc_q;
                    end
                end
                default: begin
                    pwm_q     <= 1'b0;
                    resetn_q  <= 1'b0;
                    running_q <= 1'b0;
                    clr_q     <= 1'b1;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_angle_ramp_ctrl.sv
module tb_angle_ramp_ctrl;

    logic        aclk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [11:0] prescaler_start;
    logic [11:0] prescaler_target;
    logic [15:0] ramp_div;
    logic [23:0] align_time;
    logic [11:0] angle_prescaler;
    logic        angle_gen_resetn;
    logic        pwm_en;
    logic [2:0]  state;
    logic        running;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int val;
        int gap;
    } step_t;

    step_t sb_q[$];

    angle_ramp_ctrl #(
        .PRESCALER_WIDTH (12),
        .RAMP_DIV_WIDTH  (16),
        .ALIGN_WIDTH     (24)
    ) dut (
        .aclk             (aclk),
        .reset            (reset),
        .start            (start),
        .stop             (stop),
        .prescaler_start  (prescaler_start),
        .prescaler_target (prescaler_target),
        .ramp_div         (ramp_div),
        .align_time       (align_time),
        .angle_prescaler  (angle_prescaler),
        .angle_gen_resetn (angle_gen_resetn),
        .pwm_en           (pwm_en),
        .state            (state),
        .running          (running),
        .done             (done)
    );

    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_step(input int val, input int gap);
        step_t s;
        s.val = val;
        s.gap = gap;
        sb_q.push_back(s);
    endtask

    // Watch prescaler changes and compare value and spacing with the queued steps.
    task automatic run_steps(input string tag, input int max_cyc);
        int    gap;
        int    prev;
        step_t s;
        gap  = 0;
        prev = int'(angle_prescaler);
        for (int c = 0; c < max_cyc && sb_q.size() > 0; c++) begin
            step();
            gap++;
            if (int'(angle_prescaler) != prev) begin
                s = sb_q.pop_front();
                check({tag, " value"}, angle_prescaler, s.val);
                check({tag, " gap"}, gap, s.gap);
                prev = int'(angle_prescaler);
                gap  = 0;
            end
        end
        if (sb_q.size() != 0) begin
            check({tag, " timeout"}, sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    task automatic set_cfg(input int ps, input int pt, input int rd, input int at);
        prescaler_start  = 12'(ps);
        prescaler_target = 12'(pt);
        ramp_div         = 16'(rd);
        align_time       = 24'(at);
    endtask

    initial begin
        int n_align;

        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        set_cfg(0, 0, 0, 0);
        step();
        step();
        check("rst state", state, 0);
        check("rst presc", angle_prescaler, 0);
        check("rst resetn", angle_gen_resetn, 0);
        check("rst pwm", pwm_en, 0);
        check("rst running", running, 0);
        check("rst done", done, 0);
        reset = 1'b0;
        step();

        // Reset in the middle of RAMP.
        set_cfg(200, 100, 100, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("t1 in ramp", state, 2);
        check("t1 presc200", angle_prescaler, 200);
        reset = 1'b1;
        step();
        check("t1 state", state, 0);
        check("t1 presc", angle_prescaler, 0);
        check("t1 pwm", pwm_en, 0);
        check("t1 resetn", angle_gen_resetn, 0);
        reset = 1'b0;
        step();

        // Full start-up: align then ramp 10 -> 7.
        set_cfg(10, 7, 3, 4);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t2 align state", state, 1);
        check("t2 align pwm", pwm_en, 1);
        check("t2 align resetn", angle_gen_resetn, 0);
        check("t2 align presc", angle_prescaler, 10);
        n_align = 1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (state == 3'd1) n_align++;
            else break;
        end
        check("t2 align len", n_align, 5);
        check("t2 ramp state", state, 2);
        check("t2 ramp resetn", angle_gen_resetn, 1);
        push_step(9, 5);
        push_step(8, 4);
        push_step(7, 4);
        run_steps("t2 ramp", 60);
        check("t2 not yet run", running, 0);
        step();
        check("t2 running", running, 1);
        check("t2 run state", state, 3);

        // Config changes while in RUN are ignored.
        prescaler_target = 12'd3;
        step();
        step();
        step();
        check("t6 held presc", angle_prescaler, 7);
        check("t6 held state", state, 3);

        // Stop in RUN: ramp back 7 -> 10, stop left asserted.
        stop = 1'b1;
        step();
        check("t3 rampdn state", state, 4);
        check("t3 rampdn running", running, 0);
        push_step(8, 5);
        push_step(9, 4);
        push_step(10, 4);
        run_steps("t3 rampdn", 60);
        check("t3 no early done", done, 0);
        step();
        check("t3 idle", state, 0);
        check("t3 done", done, 1);
        check("t3 pwm", pwm_en, 0);
        check("t3 resetn", angle_gen_resetn, 0);
        step();
        check("t3 done pulse", done, 0);
        stop = 1'b0;

        // start and stop together in IDLE.
        start = 1'b1;
        stop  = 1'b1;
        step();
        step();
        check("t4 both state", state, 0);
        check("t4 both pwm", pwm_en, 0);
        check("t4 both presc", angle_prescaler, 10);
        // stop during ALIGN.
        set_cfg(10, 7, 3, 4);
        stop = 1'b0;
        step();
        check("t4 align", state, 1);
        start = 1'b0;
        stop  = 1'b1;
        step();
        check("t4 abort state", state, 0);
        check("t4 abort pwm", pwm_en, 0);
        check("t4 abort done", done, 0);
        step();
        check("t4 abort done2", done, 0);
        stop = 1'b0;

        // Target above start and zero align time.
        set_cfg(10, 12, 3, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t5 align", state, 1);
        step();
        check("t5 ramp after 1", state, 2);
        step();
        check("t5 run", state, 3);
        check("t5 run presc", angle_prescaler, 10);
        check("t5 running", running, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t5 rampdn", state, 4);
        step();
        check("t5 idle", state, 0);
        check("t5 done", done, 1);

        // Illegal state code recovers to IDLE.
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("t6 pre run", state, 3);
        force dut.state_q = 3'd6;
        release dut.state_q;
        step();
        check("t6 recover state", state, 0);
        check("t6 recover pwm", pwm_en, 0);
        check("t6 recover running", running, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
